shift_exec_stage: RTL and testbench

Two-stage pipelined execute unit for RV32I shift instructions (SLL, SRL, SRA, SLLI, SRLI, SRAI). It sits between the decode/operand-read stage and the writeback arbiter. It decodes opcode/funct fields into `barrel_shifter` controls, registers operands, computes the result, and holds it in an output register. Valid/ready handshakes on both sides give full throughput with backpressure and a synchronous flush.

---
 rtl/rv32i_pkg.sv | 28 ++
 rtl/barrel_shifter.sv | 36 +++
 rtl/shift_exec_stage.sv | 120 ++++++++++++
 tb/tb_shift_exec_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and the decoded shift-control payload.
package rv32i_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned F7_W    = 7;

    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [F3_W-1:0] F3_SLL = 3'b001;
    localparam logic [F3_W-1:0] F3_SR  = 3'b101;

    localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
    localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

    // dir: 0 = left, 1 = right; arithmetic only meaningful for right shifts
    typedef struct packed {
        logic [SHAMT_W-1:0] amount;
        logic               dir;
        logic               arithmetic;
        logic               illegal;
    } shift_ctl_t;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational 32-bit shifter: logical left, logical right, arithmetic right.
// Ports:
//   data       value to shift
//   amount     shift distance 0..31
//   dir        0 = left, 1 = right
//   arithmetic sign-fill on right shift
//   result_c   shifted value (combinational)
module barrel_shifter
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0]    data,
    input  logic [SHAMT_W-1:0] amount,
    input  logic               dir,
    input  logic               arithmetic,
    output logic [XLEN-1:0]    result_c
);

    logic [XLEN-1:0] src_c;
    logic [XLEN-1:0] shr_c;
    logic            fill_c;

    // Left shifts reuse the right-shift path by bit-reversing input and output.
    always_comb begin : shift_path
        src_c    = '0;
        result_c = '0;
        for (int i = 0; i < XLEN; i++) begin
            src_c[i] = dir ? data[i] : data[XLEN-1-i];
        end
        fill_c = dir && arithmetic && data[XLEN-1];
        shr_c  = (src_c >> amount) | ({XLEN{fill_c}} & ~({XLEN{1'b1}} >> amount));
        for (int i = 0; i < XLEN; i++) begin
            result_c[i] = dir ? shr_c[i] : shr_c[XLEN-1-i];
        end
    end

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage pipelined RV32I shift execute unit (SLL/SRL/SRA and immediates).
// Stage A holds decoded operands, stage B holds the registered result.
// Ports:
//   clk, rst                  clock, async active-high reset
//   flush                     synchronous kill of both stages
//   in_valid/in_ready         upstream handshake
//   in_opcode/funct3/funct7   instruction fields for decode
//   in_rs1, in_rs2, in_shamt  value, register amount, immediate amount
//   in_rd                     destination tag
//   out_valid/out_ready       downstream handshake
//   out_result/out_rd         result (0 when illegal) and destination tag
//   out_illegal               op was not a legal RV32I shift
module shift_exec_stage
    import rv32i_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPC_W-1:0]   in_opcode,
    input  logic [F3_W-1:0]    in_funct3,
    input  logic [F7_W-1:0]    in_funct7,
    input  logic [XLEN-1:0]    in_rs1,
    input  logic [XLEN-1:0]    in_rs2,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [REG_W-1:0]   in_rd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_result,
    output logic [REG_W-1:0]   out_rd,
    output logic               out_illegal
);

    shift_ctl_t          ctl_c;
    logic                unused_rs2_hi;
    logic                a_valid;
    logic [XLEN-1:0]     a_rs1;
    shift_ctl_t          a_ctl;
    logic [REG_W-1:0]    a_rd;
    logic [XLEN-1:0]     shift_result_c;
    logic                b_adv_c;
    logic                accept_c;

    // Only the low five bits of rs2 carry a shift amount in RV32.
    assign unused_rs2_hi = ^in_rs2[XLEN-1:SHAMT_W];

    // Decode opcode/funct fields into shifter controls.
    always_comb begin : decode
        ctl_c        = '0;
        ctl_c.amount = (in_opcode == OPC_OP) ? in_rs2[SHAMT_W-1:0] : in_shamt;
        case (in_funct3)
            F3_SLL: begin
                ctl_c.dir     = 1'b0;
                ctl_c.illegal = (in_funct7 != F7_BASE);
            end
            F3_SR: begin
                ctl_c.dir        = 1'b1;
                ctl_c.arithmetic = (in_funct7 == F7_ALT);
                ctl_c.illegal    = (in_funct7 != F7_BASE) && (in_funct7 != F7_ALT);
            end
            default: ctl_c.illegal = 1'b1;
        endcase
        if ((in_opcode != OPC_OP) && (in_opcode != OPC_OP_IMM)) begin
            ctl_c.illegal = 1'b1;
        end
    end

    // Handshake: A drains into B whenever B is empty or being consumed.
    assign b_adv_c  = a_valid && (!out_valid || out_ready);
    assign in_ready = !a_valid || b_adv_c;
    assign accept_c = in_valid && in_ready;

    // Stage A operand register.
    always_ff @(posedge clk or posedge rst) begin : stage_a
        if (rst) begin
            a_valid <= 1'b0;
            a_rs1   <= '0;
            a_ctl   <= '0;
            a_rd    <= '0;
        end else if (flush) begin
            a_valid <= 1'b0;
        end else if (accept_c) begin
            a_valid <= 1'b1;
            a_rs1   <= in_rs1;
            a_ctl   <= ctl_c;
            a_rd    <= in_rd;
        end else if (b_adv_c) begin
            a_valid <= 1'b0;
        end
    end

    barrel_shifter u_shifter (
        .data       (a_rs1),
        .amount     (a_ctl.amount),
        .dir        (a_ctl.dir),
        .arithmetic (a_ctl.arithmetic),
        .result_c   (shift_result_c)
    );

    // Stage B output register; illegal ops carry a zero result.
    always_ff @(posedge clk or posedge rst) begin : stage_b
        if (rst) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_rd      <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (b_adv_c) begin
            out_valid   <= 1'b1;
            out_result  <= a_ctl.illegal ? '0 : shift_result_c;
            out_rd      <= a_rd;
            out_illegal <= a_ctl.illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: vector table, scoreboard queue,
// and hand-written sequences for stall, flush and async reset.
module tb_shift_exec_stage;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_shamt;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_illegal;

    shift_exec_stage dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_funct3   (in_funct3),
        .in_funct7   (in_funct7),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_shamt    (in_shamt),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  shamt;
        logic [4:0]  rd;
        logic [31:0] exp_res;
        logic        exp_ill;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t  sb_q[$];
    exp_t  mon_e;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    pop_log[$];
    logic  rand_ready = 1'b0;
    vec_t  tv[14];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour written with plain shift operators.
    function automatic exp_t model(input vec_t v);
        exp_t        e;
        logic [4:0]  amt;
        logic [31:0] r;
        logic        ill;
        amt = (v.opc == 7'b0110011) ? v.rs2[4:0] : v.shamt;
        r   = 32'h0;
        ill = 1'b1;
        if (v.opc == 7'b0110011 || v.opc == 7'b0010011) begin
            if (v.f3 == 3'b001 && v.f7 == 7'h00) begin
                ill = 1'b0; r = v.rs1 << amt;
            end else if (v.f3 == 3'b101 && v.f7 == 7'h00) begin
                ill = 1'b0; r = v.rs1 >> amt;
            end else if (v.f3 == 3'b101 && v.f7 == 7'h20) begin
                ill = 1'b0; r = 32'($signed(v.rs1) >>> amt);
            end
        end
        e.res = ill ? 32'h0 : r;
        e.rd  = v.rd;
        e.ill = ill;
        return e;
    endfunction

    function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] shamt,
                                input logic [4:0] rd, input logic [31:0] exp_res, input logic exp_ill);
        vec_t v;
        v.opc = opc; v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2;
        v.shamt = shamt; v.rd = rd; v.exp_res = exp_res; v.exp_ill = exp_ill;
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        int   r;
        r = $urandom_range(0, 9);
        v.opc = (r == 0) ? 7'b1100011 : ((r % 2 == 1) ? 7'b0110011 : 7'b0010011);
        r = $urandom_range(0, 7);
        v.f3 = (r < 3) ? 3'b001 : ((r < 6) ? 3'b101 : 3'($urandom_range(0, 7)));
        r = $urandom_range(0, 9);
        v.f7 = (r < 5) ? 7'h00 : ((r < 8) ? 7'h20 : 7'($urandom_range(0, 127)));
        v.rs1 = $urandom;
        v.rs2 = $urandom;
        v.shamt = 5'($urandom_range(0, 31));
        v.rd = 5'($urandom_range(0, 31));
        v.exp_res = 32'h0;
        v.exp_ill = 1'b0;
        return v;
    endfunction

    // Scoreboard: every completed output handshake is compared with the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            pop_log.push_back(cyc);
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got rd %0d result %h, expected no output", out_rd, out_result);
            end else begin
                mon_e = sb_q.pop_front();
                check("out_result", out_result, mon_e.res);
                check("out_rd", 32'(out_rd), 32'(mon_e.rd));
                check("out_illegal", 32'(out_illegal), 32'(mon_e.ill));
            end
        end
    end

    // Random backpressure, applied between edges so it is stable at sampling.
    always @(posedge clk) begin
        #2;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic drive_vec(input vec_t v);
        in_opcode = v.opc; in_funct3 = v.f3; in_funct7 = v.f7;
        in_rs1 = v.rs1; in_rs2 = v.rs2; in_shamt = v.shamt; in_rd = v.rd;
        in_valid = 1'b1;
    endtask

    // Offer v until accepted; returns 1ns after the accepting edge.
    task automatic send(input vec_t v, input exp_t e);
        logic acc;
        int   budget;
        acc = 1'b0;
        budget = 0;
        drive_vec(v);
        while (!acc && budget < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        in_valid = 1'b0;
        if (acc) sb_q.push_back(e);
        else begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: got in_ready low for %0d cycles, expected acceptance", budget);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        vec_t v;
        int   budget;
        int   acc_start;

        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        exp_t e;
        vec_t v;
        int   budget;

        tv[0]  = mk(7'b0110011, 3'b001, 7'h00, 32'h0000_0001, 32'h0000_001F, 5'd3,  5'd5,  32'h8000_0000, 1'b0);
        tv[1]  = mk(7'b0010011, 3'b101, 7'h20, 32'h8000_0010, 32'h0000_001F, 5'd4,  5'd6,  32'hF800_0001, 1'b0);
        tv[2]  = mk(7'b0010011, 3'b101, 7'h00, 32'h8000_0010, 32'h0000_001F, 5'd4,  5'd7,  32'h0800_0001, 1'b0);
        tv[3]  = mk(7'b0010011, 3'b001, 7'h01, 32'h0000_FFFF, 32'h0000_0000, 5'd3,  5'd8,  32'h0000_0000, 1'b1);
        tv[4]  = mk(7'b0110011, 3'b000, 7'h00, 32'h0000_1234, 32'h0000_0002, 5'd0,  5'd9,  32'h0000_0000, 1'b1);
        tv[5]  = mk(7'b0110011, 3'b101, 7'h20, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  5'd10, 32'hFFFF_FFFF, 1'b0);
        tv[6]  = mk(7'b0010011, 3'b001, 7'h00, 32'hDEAD_BEEF, 32'h0000_0007, 5'd0,  5'd11, 32'hDEAD_BEEF, 1'b0);
        tv[7]  = mk(7'b0110011, 3'b101, 7'h00, 32'h8000_0001, 32'h0000_0020, 5'd9,  5'd12, 32'h8000_0001, 1'b0);
        tv[8]  = mk(7'b0010011, 3'b101, 7'h20, 32'h8000_0001, 32'h0000_0003, 5'd0,  5'd13, 32'h8000_0001, 1'b0);
        tv[9]  = mk(7'b0110111, 3'b001, 7'h00, 32'h0000_0001, 32'h0000_0001, 5'd1,  5'd14, 32'h0000_0000, 1'b1);
        tv[10] = mk(7'b0110011, 3'b101, 7'h21, 32'h8000_0000, 32'h0000_0001, 5'd0,  5'd15, 32'h0000_0000, 1'b1);
        tv[11] = mk(7'b0110011, 3'b001, 7'h20, 32'h0000_0001, 32'h0000_0001, 5'd0,  5'd16, 32'h0000_0000, 1'b1);
        tv[12] = mk(7'b0110011, 3'b101, 7'h00, 32'hF000_0000, 32'h0000_0004, 5'd17, 5'd17, 32'h0F00_0000, 1'b0);
        tv[13] = mk(7'b0010011, 3'b101, 7'h00, 32'h8000_0000, 32'h0000_0002, 5'd31, 5'd31, 32'h0000_0001, 1'b0);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
        in_rs1 = '0; in_rs2 = '0; in_shamt = '0; in_rd = '0;

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
        check("rst_out_illegal", 32'(out_illegal), 32'd0);
        check("rst_a_valid", 32'(dut.a_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        step();
        rst = 1'b0;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Vector table, one op at a time with latency check
        for (int i = 0; i < 14; i++) begin
            e.res = tv[i].exp_res; e.rd = tv[i].rd; e.ill = tv[i].exp_ill;
            send(tv[i], e);
            check("latency_not_yet", 32'(out_valid), 32'd0);
            step();
            check("latency_valid", 32'(out_valid), 32'd1);
            step();
        end
        check("table_drained", 32'(sb_q.size()), 32'd0);

        // Back-to-back stream: 8 results on consecutive cycles
        pop_log.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = rand_vec();
            send(v, model(v));
        end
        repeat (4) step();
        check("stream_count", 32'(pop_log.size()), 32'd8);
        for (int i = 1; i < pop_log.size(); i++) begin
            check("stream_no_bubble", 32'(pop_log[i] - pop_log[i-1]), 32'd1);
        end

        // Backpressure: B fills, A fills, then in_ready falls and outputs hold
        out_ready = 1'b0;
        v = tv[1];
        e = model(v);
        send(v, e);
        step();
        check("stall_b_only_in_ready", 32'(in_ready), 32'd1);
        send(tv[12], model(tv[12]));
        check("stall_in_ready_low", 32'(in_ready), 32'd0);
        check("stall_a_valid", 32'(dut.a_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_result", out_result, e.res);
            check("stall_out_rd", 32'(out_rd), 32'(e.rd));
        end
        out_ready = 1'b1;
        repeat (4) step();
        check("stall_drained", 32'(sb_q.size()), 32'd0);

        // Flush with both stages full and an offered op on the same edge
        out_ready = 1'b0;
        send(tv[0], model(tv[0]));
        step();
        send(tv[2], model(tv[2]));
        out_ready = 1'b1;
        drive_vec(tv[6]);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_a_valid", 32'(dut.a_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("flush_no_output", 32'(out_valid), 32'd0);
        end

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        send(tv[5], model(tv[5]));
        step();
        send(tv[13], model(tv[13]));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_a_valid", 32'(dut.a_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        sb_q.delete();
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("post_rst_no_output", 32'(out_valid), 32'd0);
        end

        // Random ops under random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            v = rand_vec();
            send(v, model(v));
        end
        step();
        rand_ready = 1'b0;
        out_ready = 1'b1;
        budget = 0;
        while (sb_q.size() != 0 && budget < 100) begin
            step();
            budget++;
        end
        check("random_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
